// File: rtl/switch_debouncer_if.sv
//------------------------------------------------------------------------------
// switch_debouncer_if : raw switch pins in, debounced levels and strobes out.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_change;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  sw_change
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output sw_change
    );
endinterface

`default_nettype wire

// File: rtl/switch_debouncer.sv
//------------------------------------------------------------------------------
// switch_debouncer : 2-flop synchroniser plus independent per-bit debounce
//                    with registered level, rise/fall and change strobes.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    switch_debouncer_if.slave  sw
);

    localparam logic [CNT_W-1:0] c_TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;

    logic [WIDTH-1:0] w_db_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_db;
        logic             w_rise;
        logic             w_fall;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= ST_STABLE;
                r_cnt   <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
            end
        end

        // The count in STABLE is always zero, and DEBOUNCE_CYCLES >= 2 keeps
        // the terminal count above zero, so commits only happen from PENDING.
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = '0;
            w_db        = r_db[gi];
            w_rise      = 1'b0;
            w_fall      = 1'b0;
            case (r_state)
                ST_STABLE: begin
                    if (r_sync2[gi] != r_db[gi]) begin
                        w_state_nxt = ST_PENDING;
                        w_cnt_nxt   = CNT_W'(1);
                    end
                end
                ST_PENDING: begin
                    if (r_sync2[gi] == r_db[gi]) begin
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == c_TERM_CNT) begin
                        w_state_nxt = ST_STABLE;
                        w_db        = r_sync2[gi];
                        w_rise      = r_sync2[gi];
                        w_fall      = ~r_sync2[gi];
                    end else begin
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                end
            endcase
        end

        assign w_db_nxt[gi]   = w_db;
        assign w_rise_nxt[gi] = w_rise;
        assign w_fall_nxt[gi] = w_fall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_db     <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            r_sync1  <= sw.sw_raw;
            r_sync2  <= r_sync1;
            r_db     <= w_db_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_change <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign sw.sw_db     = r_db;
    assign sw.sw_rise   = r_rise;
    assign sw.sw_fall   = r_fall;
    assign sw.sw_change = r_change;

endmodule

`default_nettype wire
